// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace encoder branch-map path.
package trdb_pkg;

    localparam int unsigned BMAP_LEN   = 31;
    localparam int unsigned BMAP_CNT_W = 5;

    // Controller state: IDLE holds no snapshot, HOLD offers one to the emitter.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } bmap_ctrl_state_e;

    // Why the map content was emitted.
    typedef enum logic [1:0] {
        ReasonFull    = 2'd0,
        ReasonSync    = 2'd1,
        ReasonTimeout = 2'd2
    } bmap_reason_e;

    typedef struct packed {
        logic [BMAP_LEN-1:0]   map;
        logic [BMAP_CNT_W-1:0] branches;
        bmap_reason_e          reason;
    } bmap_pkt_t;

endpackage

// File: rtl/trdb_bmap_snapshot.sv
// One-entry holding register for a captured branch map. The FSM in the
// controller owns the valid flag. A load while a snapshot is being
// accepted replaces it in place, which gives back-to-back emission.
module trdb_bmap_snapshot
    import trdb_pkg::*;
#(
    parameter int unsigned MAP_LEN = BMAP_LEN,
    parameter int unsigned CNT_W   = BMAP_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [MAP_LEN-1:0] map_i,
    input  logic [CNT_W-1:0]   branches_i,
    input  bmap_reason_e       reason_i,
    output logic [MAP_LEN-1:0] map_o,
    output logic [CNT_W-1:0]   branches_o,
    output bmap_reason_e       reason_o
);

    logic [MAP_LEN-1:0] map_q, map_d;
    logic [CNT_W-1:0]   branches_q, branches_d;
    bmap_reason_e       reason_q, reason_d;

    // Next-state: take the new snapshot on load, otherwise hold.
    always_comb begin
        map_d      = map_q;
        branches_d = branches_q;
        reason_d   = reason_q;
        if (load_i) begin
            map_d      = map_i;
            branches_d = branches_i;
            reason_d   = reason_i;
        end
    end

    // Snapshot storage; cleared on reset so a discarded packet leaves no trace.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            map_q      <= '0;
            branches_q <= '0;
            reason_q   <= ReasonFull;
        end else begin
            map_q      <= map_d;
            branches_q <= branches_d;
            reason_q   <= reason_d;
        end
    end

    assign map_o      = map_q;
    assign branches_o = branches_q;
    assign reason_o   = reason_q;

endmodule

// File: rtl/trdb_branch_map_ctrl.sv
// Branch-map controller: forwards retired branches into the map, decides
// when the map must be emitted, snapshots it for the packet emitter and
// flushes the map the cycle after capture.
// Optional idle-timeout emission is enabled by defining TRDB_BMAP_CTRL_TIMEOUT_EN.
module trdb_branch_map_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned MAP_LEN        = BMAP_LEN,
    parameter int unsigned CNT_W          = BMAP_CNT_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               branch_valid_i,
    input  logic               branch_taken_i,
    input  logic               sync_req_i,
    output logic               bm_valid_o,
    output logic               bm_taken_o,
    output logic               bm_flush_o,
    input  logic [MAP_LEN-1:0] bm_map_i,
    input  logic [CNT_W-1:0]   bm_branches_i,
    output logic               pkt_valid_o,
    input  logic               pkt_ready_i,
    output logic [MAP_LEN-1:0] pkt_map_o,
    output logic [CNT_W-1:0]   pkt_branches_o,
    output logic [1:0]         pkt_reason_o,
    output logic               stall_o,
    output logic               overflow_o
);

    bmap_ctrl_state_e state_q, state_d;
    logic             flush_q, flush_d;
    logic             full_q, full_d;
    logic             sync_q, sync_d;
    logic             overflow_q, overflow_d;

    logic             drop;
    logic             eval;
    logic             map_full;
    logic             map_empty;
    logic             trig_full;
    logic             trig_sync;
    logic             trig_timeout;
    logic             trigger;
    logic             capture;
    bmap_reason_e     reason;
    bmap_reason_e     snap_reason;

    // The map inputs are next-state views; the flush cycle shows post-flush
    // contents, so triggers are only evaluated outside it.
    assign eval      = ~flush_q;
    assign map_full  = (bm_branches_i == CNT_W'(MAP_LEN));
    assign map_empty = (bm_branches_i == '0);

    // Only registered state gates the write, so no loop forms through the map.
    assign drop       = full_q & ~flush_q;
    assign bm_valid_o = branch_valid_i & ~drop;
    assign bm_taken_o = branch_taken_i;
    assign bm_flush_o = flush_q;

    assign trig_full = eval & map_full;
    assign trig_sync = eval & (sync_q | sync_req_i) & ~map_empty;

`ifdef TRDB_BMAP_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Idle counter: runs while the map holds branches, saturates at the threshold.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (capture || flush_q) begin
            to_cnt_d = '0;
        end else if (!map_empty && (to_cnt_q != TO_W'(TIMEOUT_CYCLES))) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign trig_timeout = eval & ~map_empty & (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
`else
    assign trig_timeout = 1'b0;
`endif

    assign trigger = trig_full | trig_sync | trig_timeout;
    // A held snapshot can be replaced only in the cycle the emitter takes it.
    assign capture = trigger & ((state_q == StIdle) | pkt_ready_i);

    // Reason selection, FULL beats SYNC beats TIMEOUT.
    always_comb begin
        reason = ReasonTimeout;
        if (trig_full) begin
            reason = ReasonFull;
        end else if (trig_sync) begin
            reason = ReasonSync;
        end
    end

    // Flag next-state: flush pulse, full tracking, pending sync, sticky overflow.
    always_comb begin
        flush_d    = capture;
        full_d     = map_full & ~capture;
        overflow_d = overflow_q | (branch_valid_i & drop);
        sync_d     = sync_q | sync_req_i;
        if (capture) begin
            sync_d = 1'b0;
        end else if (eval && map_empty) begin
            // Nothing to emit, so the request is already satisfied.
            sync_d = 1'b0;
        end
    end

    // Flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_q    <= 1'b0;
            full_q     <= 1'b0;
            sync_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            flush_q    <= flush_d;
            full_q     <= full_d;
            sync_q     <= sync_d;
            overflow_q <= overflow_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!capture && pkt_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        pkt_valid_o = (state_q == StHold);
        stall_o     = full_q & (state_q == StHold);
        overflow_o  = overflow_q;
    end

    trdb_bmap_snapshot #(
        .MAP_LEN (MAP_LEN),
        .CNT_W   (CNT_W)
    ) u_snapshot (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (capture),
        .map_i      (bm_map_i),
        .branches_i (bm_branches_i),
        .reason_i   (reason),
        .map_o      (pkt_map_o),
        .branches_o (pkt_branches_o),
        .reason_o   (snap_reason)
    );

    assign pkt_reason_o = snap_reason;

endmodule

// File: tb/tb_trdb_branch_map_ctrl.sv
// Directed bench for trdb_branch_map_ctrl with a behavioural branch map.
module tb_trdb_branch_map_ctrl;

    localparam int unsigned MAP_LEN = 31;
    localparam int unsigned CNT_W   = 5;
`ifdef TRDB_BMAP_CTRL_TIMEOUT_EN
    localparam int unsigned TO_CYC  = 8;
`else
    localparam int unsigned TO_CYC  = 255;
`endif

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               branch_valid_i;
    logic               branch_taken_i;
    logic               sync_req_i;
    logic               bm_valid_o;
    logic               bm_taken_o;
    logic               bm_flush_o;
    logic [MAP_LEN-1:0] bm_map_i;
    logic [CNT_W-1:0]   bm_branches_i;
    logic               pkt_valid_o;
    logic               pkt_ready_i;
    logic [MAP_LEN-1:0] pkt_map_o;
    logic [CNT_W-1:0]   pkt_branches_o;
    logic [1:0]         pkt_reason_o;
    logic               stall_o;
    logic               overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    trdb_branch_map_ctrl #(
        .MAP_LEN        (MAP_LEN),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .branch_valid_i (branch_valid_i),
        .branch_taken_i (branch_taken_i),
        .sync_req_i     (sync_req_i),
        .bm_valid_o     (bm_valid_o),
        .bm_taken_o     (bm_taken_o),
        .bm_flush_o     (bm_flush_o),
        .bm_map_i       (bm_map_i),
        .bm_branches_i  (bm_branches_i),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready_i),
        .pkt_map_o      (pkt_map_o),
        .pkt_branches_o (pkt_branches_o),
        .pkt_reason_o   (pkt_reason_o),
        .stall_o        (stall_o),
        .overflow_o     (overflow_o)
    );

    // Branch map model: stores the inverted outcome, flush restarts at entry 0,
    // and exposes its next-state contents to the controller.
    logic [MAP_LEN-1:0] mdl_map_q;
    logic [CNT_W-1:0]   mdl_cnt_q;

    always_comb begin
        bm_map_i      = mdl_map_q;
        bm_branches_i = mdl_cnt_q;
        if (bm_flush_o) begin
            bm_map_i      = '0;
            bm_branches_i = '0;
            if (bm_valid_o) begin
                bm_map_i[0]   = ~bm_taken_o;
                bm_branches_i = 1;
            end
        end else if (bm_valid_o && (mdl_cnt_q < CNT_W'(MAP_LEN))) begin
            bm_map_i[mdl_cnt_q] = ~bm_taken_o;
            bm_branches_i       = mdl_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mdl_map_q <= '0;
            mdl_cnt_q <= '0;
        end else begin
            mdl_map_q <= bm_map_i;
            mdl_cnt_q <= bm_branches_i;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_branch(input logic taken);
        branch_valid_i = 1'b1;
        branch_taken_i = taken;
        tick();
        branch_valid_i = 1'b0;
        branch_taken_i = 1'b0;
    endtask

    task automatic do_sync();
        sync_req_i = 1'b1;
        tick();
        sync_req_i = 1'b0;
    endtask

    initial begin
        rst_i          = 1'b1;
        branch_valid_i = 1'b0;
        branch_taken_i = 1'b0;
        sync_req_i     = 1'b0;
        pkt_ready_i    = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        check("rst_pkt_valid", 64'(pkt_valid_o), 64'd0);
        check("rst_flush", 64'(bm_flush_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);

`ifdef TRDB_BMAP_CTRL_TIMEOUT_EN
        begin
            int waited;
            pkt_ready_i = 1'b1;
            do_branch(1'b1);
            waited = 0;
            while (!pkt_valid_o && waited < 20) begin
                tick();
                waited++;
            end
            check("to_wait", 64'(waited), 64'd8);
            check("to_reason", 64'(pkt_reason_o), 64'd2);
            check("to_branches", 64'(pkt_branches_o), 64'd1);
        end
`else
        // 31 taken branches fill the map and capture on the last one.
        pkt_ready_i = 1'b1;
        for (int i = 0; i < 31; i++) begin
            if (i == 30) check("full_pre_valid", 64'(pkt_valid_o), 64'd0);
            do_branch(1'b1);
        end
        check("full_valid", 64'(pkt_valid_o), 64'd1);
        check("full_branches", 64'(pkt_branches_o), 64'd31);
        check("full_map", 64'(pkt_map_o), 64'd0);
        check("full_reason", 64'(pkt_reason_o), 64'd0);
        check("full_flush", 64'(bm_flush_o), 64'd1);
        tick();
        check("full_accepted", 64'(pkt_valid_o), 64'd0);
        check("full_flush_end", 64'(bm_flush_o), 64'd0);

        // T,N,T then sync request.
        pkt_ready_i = 1'b0;
        do_branch(1'b1);
        do_branch(1'b0);
        do_branch(1'b1);
        check("sync_pre_valid", 64'(pkt_valid_o), 64'd0);
        do_sync();
        check("sync_valid", 64'(pkt_valid_o), 64'd1);
        check("sync_map", 64'(pkt_map_o), 64'h2);
        check("sync_branches", 64'(pkt_branches_o), 64'd3);
        check("sync_reason", 64'(pkt_reason_o), 64'd1);
        pkt_ready_i = 1'b1;
        tick();
        check("sync_accepted", 64'(pkt_valid_o), 64'd0);

        // Sync on an empty map emits nothing and leaves nothing pending.
        do_sync();
        check("sync_empty_valid", 64'(pkt_valid_o), 64'd0);
        do_branch(1'b1);
        check("sync_cleared", 64'(pkt_valid_o), 64'd0);
        do_sync();
        check("one_valid", 64'(pkt_valid_o), 64'd1);
        check("one_branches", 64'(pkt_branches_o), 64'd1);
        check("one_map", 64'(pkt_map_o), 64'd0);

        // A branch in the flush cycle lands in entry 0 of the fresh map.
        branch_valid_i = 1'b1;
        branch_taken_i = 1'b0;
        #1;
        check("flush_cycle_flush", 64'(bm_flush_o), 64'd1);
        check("flush_cycle_bm_valid", 64'(bm_valid_o), 64'd1);
        tick();
        branch_valid_i = 1'b0;
        do_sync();
        check("flushbr_valid", 64'(pkt_valid_o), 64'd1);
        check("flushbr_branches", 64'(pkt_branches_o), 64'd1);
        check("flushbr_map", 64'(pkt_map_o), 64'd1);
        tick();

        // 62 branches with the emitter stalled: second fill stalls, 63rd drops.
        pkt_ready_i = 1'b0;
        for (int i = 0; i < 62; i++) begin
            do_branch(1'(i % 2));
        end
        check("stall_stall", 64'(stall_o), 64'd1);
        check("stall_held_branches", 64'(pkt_branches_o), 64'd31);
        check("stall_held_map", 64'(pkt_map_o), 64'h5555_5555);
        check("stall_no_overflow", 64'(overflow_o), 64'd0);
        branch_valid_i = 1'b1;
        branch_taken_i = 1'b1;
        #1;
        check("drop_bm_valid", 64'(bm_valid_o), 64'd0);
        tick();
        branch_valid_i = 1'b0;
        check("drop_overflow", 64'(overflow_o), 64'd1);
        pkt_ready_i = 1'b1;
        tick();
        check("b2b_valid", 64'(pkt_valid_o), 64'd1);
        check("b2b_branches", 64'(pkt_branches_o), 64'd31);
        check("b2b_map", 64'(pkt_map_o), 64'h2AAA_AAAA);
        check("b2b_reason", 64'(pkt_reason_o), 64'd0);
        check("b2b_stall", 64'(stall_o), 64'd0);
        check("b2b_flush", 64'(bm_flush_o), 64'd1);
        tick();
        check("b2b_accepted", 64'(pkt_valid_o), 64'd0);
        check("overflow_sticky", 64'(overflow_o), 64'd1);

        // Reset while holding a snapshot discards it.
        pkt_ready_i = 1'b0;
        do_branch(1'b0);
        do_sync();
        check("hold_valid", 64'(pkt_valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("rst_hold_valid", 64'(pkt_valid_o), 64'd0);
        check("rst_hold_overflow", 64'(overflow_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();
        check("post_rst_valid", 64'(pkt_valid_o), 64'd0);
        check("post_rst_branches", 64'(pkt_branches_o), 64'd0);
        check("post_rst_flush", 64'(bm_flush_o), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
